// File: rtl/aes_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : aes_req_scheduler
// Brief   : Round-robin scheduler sharing one AES core among NREQ requesters.
//           Optional BUSY watchdog enabled by macro AES_SCHED_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module aes_req_scheduler #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int ID_W          = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*128-1:0]  req_plaintext,
    input  logic [NREQ*3-1:0]    req_key_len,
    output logic [NREQ-1:0]      req_ready,
    output logic                 core_start,
    output logic [127:0]         core_plaintext,
    output logic [2:0]           core_key_len,
    input  logic                 core_done,
    input  logic [127:0]         core_ciphertext,
    output logic [ID_W-1:0]      key_bank_sel,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic [127:0]         resp_ciphertext,
    output logic                 resp_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_BUSY  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ID_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [NREQ-1:0]   r_req_ready, w_req_ready_nxt;
    logic              r_core_start, w_core_start_nxt;
    logic [127:0]      r_core_pt, w_core_pt_nxt;
    logic [2:0]        r_core_kl, w_core_kl_nxt;
    logic [ID_W-1:0]   r_bank_sel, w_bank_sel_nxt;
    logic              r_resp_valid, w_resp_valid_nxt;
    logic [ID_W-1:0]   r_resp_id, w_resp_id_nxt;
    logic [127:0]      r_resp_ct, w_resp_ct_nxt;
    logic              r_resp_err, w_resp_err_nxt;

    logic [127:0]      w_pt_arr [NREQ];
    logic [2:0]        w_kl_arr [NREQ];
    logic              w_found;
    logic [ID_W-1:0]   w_win;

    genvar g;
    generate
        for (g = 0; g < NREQ; g++) begin : g_unpack
            assign w_pt_arr[g] = req_plaintext[128*g +: 128];
            assign w_kl_arr[g] = req_key_len[3*g +: 3];
        end
    endgenerate

    // Rotate so bit 0 is the requester at rr_ptr; first set bit wins.
    always_comb begin
        logic [2*NREQ-1:0] v_dbl;
        logic [NREQ-1:0]   v_rot;
        int                v_sum;
        v_dbl   = {req_valid, req_valid} >> r_rr_ptr;
        v_rot   = v_dbl[NREQ-1:0];
        v_sum   = 0;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && v_rot[0]) begin
                w_found = 1'b1;
                v_sum   = int'(r_rr_ptr) + k;
                if (v_sum >= NREQ) begin
                    v_sum = v_sum - NREQ;
                end
                w_win = v_sum[ID_W-1:0];
            end
            v_rot = v_rot >> 1;
        end
    end

`ifdef AES_SCHED_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_cnt_w-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_req_ready_nxt  = '0;
        w_core_start_nxt = 1'b0;
        w_core_pt_nxt    = r_core_pt;
        w_core_kl_nxt    = r_core_kl;
        w_bank_sel_nxt   = r_bank_sel;
        w_resp_valid_nxt = r_resp_valid;
        w_resp_id_nxt    = r_resp_id;
        w_resp_ct_nxt    = r_resp_ct;
        w_resp_err_nxt   = r_resp_err;
`ifdef AES_SCHED_TIMEOUT_EN
        w_tmo_cnt_nxt    = r_tmo_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_req_ready_nxt[w_win] = 1'b1;
                    w_core_pt_nxt  = w_pt_arr[w_win];
                    w_core_kl_nxt  = w_kl_arr[w_win];
                    w_bank_sel_nxt = w_win;
                    w_resp_id_nxt  = w_win;
                    w_rr_ptr_nxt   = (w_win == ID_W'(NREQ - 1)) ? '0 : w_win + 1'b1;
                    if (!$onehot(w_kl_arr[w_win])) begin
                        // Malformed key length: answer with an error, core untouched.
                        w_resp_valid_nxt = 1'b1;
                        w_resp_err_nxt   = 1'b1;
                        w_resp_ct_nxt    = '0;
                        w_state_nxt      = S_RESP;
                    end else begin
                        w_state_nxt = S_GRANT;
                    end
                end
            end
            S_GRANT: begin
                w_core_start_nxt = 1'b1;
`ifdef AES_SCHED_TIMEOUT_EN
                w_tmo_cnt_nxt    = '0;
`endif
                w_state_nxt      = S_BUSY;
            end
            S_BUSY: begin
                if (core_done) begin
                    w_resp_valid_nxt = 1'b1;
                    w_resp_err_nxt   = 1'b0;
                    w_resp_ct_nxt    = core_ciphertext;
                    w_state_nxt      = S_RESP;
                end
`ifdef AES_SCHED_TIMEOUT_EN
                else if (r_tmo_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1)) begin
                    w_resp_valid_nxt = 1'b1;
                    w_resp_err_nxt   = 1'b1;
                    w_resp_ct_nxt    = '0;
                    w_state_nxt      = S_RESP;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
                end
`endif
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_resp_valid_nxt = 1'b0;
                    w_resp_err_nxt   = 1'b0;
                    w_state_nxt      = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_req_ready  <= '0;
            r_core_start <= 1'b0;
            r_core_pt    <= '0;
            r_core_kl    <= '0;
            r_bank_sel   <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_ct    <= '0;
            r_resp_err   <= 1'b0;
`ifdef AES_SCHED_TIMEOUT_EN
            r_tmo_cnt    <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_core_start <= w_core_start_nxt;
            r_core_pt    <= w_core_pt_nxt;
            r_core_kl    <= w_core_kl_nxt;
            r_bank_sel   <= w_bank_sel_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_id    <= w_resp_id_nxt;
            r_resp_ct    <= w_resp_ct_nxt;
            r_resp_err   <= w_resp_err_nxt;
`ifdef AES_SCHED_TIMEOUT_EN
            r_tmo_cnt    <= w_tmo_cnt_nxt;
`endif
        end
    end

    assign req_ready       = r_req_ready;
    assign core_start      = r_core_start;
    assign core_plaintext  = r_core_pt;
    assign core_key_len    = r_core_kl;
    assign key_bank_sel    = r_bank_sel;
    assign resp_valid      = r_resp_valid;
    assign resp_id         = r_resp_id;
    assign resp_ciphertext = r_resp_ct;
    assign resp_err        = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes_req_scheduler
// Brief   : Directed self-checking bench for aes_req_scheduler (NREQ=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_aes_req_scheduler;

    localparam int NREQ = 4;
    localparam logic [127:0] PT_A = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] CT_A = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*128-1:0] req_plaintext;
    logic [NREQ*3-1:0]   req_key_len;
    logic [NREQ-1:0]     req_ready;
    logic                core_start;
    logic [127:0]        core_plaintext;
    logic [2:0]          core_key_len;
    logic                core_done;
    logic [127:0]        core_ciphertext;
    logic [1:0]          key_bank_sel;
    logic                resp_valid;
    logic                resp_ready;
    logic [1:0]          resp_id;
    logic [127:0]        resp_ciphertext;
    logic                resp_err;

    int n_checks = 0;
    int n_pass   = 0;
    int start_count = 0;

    always #5 clk = ~clk;

    aes_req_scheduler #(.NREQ(NREQ), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_plaintext(req_plaintext), .req_key_len(req_key_len),
        .req_ready(req_ready),
        .core_start(core_start), .core_plaintext(core_plaintext), .core_key_len(core_key_len),
        .core_done(core_done), .core_ciphertext(core_ciphertext),
        .key_bank_sel(key_bank_sel),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_ciphertext(resp_ciphertext), .resp_err(resp_err)
    );

    always @(negedge clk) if (core_start === 1'b1) start_count++;

    function automatic logic [127:0] pt_of(input int i);
        logic [31:0] w;
        w = 32'hC0DE0000 + 32'(i);
        return {4{w}};
    endfunction

    // Stand-in for the AES core: known vector, otherwise a fixed scramble.
    function automatic logic [127:0] ct_model(input logic [127:0] pt);
        if (pt == PT_A) return CT_A;
        return {pt[63:0], pt[127:64]} ^ 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_default_inputs();
        req_valid       = '0;
        core_done       = 1'b0;
        core_ciphertext = '0;
        resp_ready      = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_plaintext[128*i +: 128] = pt_of(i);
            req_key_len[3*i +: 3]       = 3'b001;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    // Runs one job end to end as host + core; ok=0 when any bounded wait expires.
    task automatic serve(input int lat, output int gid, output int rid,
                         output logic [127:0] ct, output logic err, output bit ok);
        int n;
        ok = 1'b0; gid = -1; rid = -1; ct = '0; err = 1'b0;
        n = 0;
        while (req_ready == '0 && n < 20) begin tick(); n++; end
        if (req_ready == '0) return;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
        if (!resp_valid) begin
            tick();
            repeat (lat) tick();
            core_ciphertext = ct_model(core_plaintext);
            core_done = 1'b1;
            tick();
            core_done = 1'b0;
            core_ciphertext = '0;
        end
        n = 0;
        while (!resp_valid && n < 20) begin tick(); n++; end
        if (!resp_valid) return;
        rid = int'(resp_id); ct = resp_ciphertext; err = resp_err;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        set_default_inputs();
        req_valid = 4'b1111;
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (req_ready !== 4'b0000) $display("FAIL reset_req_ready actual=%b required=0000", req_ready); else n_pass++;
        n_checks++;
        if (core_start !== 1'b0) $display("FAIL reset_core_start actual=%b required=0", core_start); else n_pass++;
        n_checks++;
        if (core_plaintext !== 128'd0 || core_key_len !== 3'd0 || key_bank_sel !== 2'd0)
            $display("FAIL reset_core_side actual=%h/%b/%0d required=0/000/0", core_plaintext, core_key_len, key_bank_sel);
        else n_pass++;
        n_checks++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_id !== 2'd0 || resp_ciphertext !== 128'd0)
            $display("FAIL reset_resp actual=%b/%b/%0d/%h required=0/0/0/0", resp_valid, resp_err, resp_id, resp_ciphertext);
        else n_pass++;
        req_valid = '0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int n;
        req_plaintext[128*2 +: 128] = PT_A;
        req_valid = 4'b0100;
        n = 0;
        while (req_ready == '0 && n < 20) begin tick(); n++; end
        n_checks++;
        if (req_ready !== 4'b0100 || key_bank_sel !== 2'd2 || core_start !== 1'b0)
            $display("FAIL single_grant actual=%b/%0d/%b required=0100/2/0", req_ready, key_bank_sel, core_start);
        else n_pass++;
        req_valid = 4'b0000;
        tick();
        n_checks++;
        if (core_start !== 1'b1 || req_ready !== 4'b0000)
            $display("FAIL single_start actual=%b/%b required=1/0000", core_start, req_ready);
        else n_pass++;
        n_checks++;
        if (core_plaintext !== PT_A || core_key_len !== 3'b001)
            $display("FAIL single_core_in actual=%h/%b required=%h/001", core_plaintext, core_key_len, PT_A);
        else n_pass++;
        tick();
        n_checks++;
        if (core_start !== 1'b0) $display("FAIL single_start_pulse actual=%b required=0", core_start); else n_pass++;
        tick();
        n_checks++;
        if (core_plaintext !== PT_A || key_bank_sel !== 2'd2 || resp_valid !== 1'b0)
            $display("FAIL single_busy_hold actual=%h/%0d/%b required=%h/2/0", core_plaintext, key_bank_sel, resp_valid, PT_A);
        else n_pass++;
        core_ciphertext = CT_A;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        core_ciphertext = '0;
        n_checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_err !== 1'b0 || resp_ciphertext !== CT_A)
            $display("FAIL single_resp actual=%b/%0d/%b/%h required=1/2/0/%h", resp_valid, resp_id, resp_err, resp_ciphertext, CT_A);
        else n_pass++;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0) $display("FAIL single_resp_clear actual=%b required=0", resp_valid); else n_pass++;
        req_plaintext[128*2 +: 128] = pt_of(2);
    endtask

    task automatic test_round_robin();
        int gid, rid;
        logic [127:0] ct;
        logic err;
        bit ok;
        do_reset();
        req_valid = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            serve(2, gid, rid, ct, err, ok);
            n_checks++;
            if (!ok || gid != (j % 4) || rid != (j % 4))
                $display("FAIL rr_order job=%0d actual=%0d/%0d ok=%0d required=%0d", j, gid, rid, ok, j % 4);
            else n_pass++;
            n_checks++;
            if (ct !== ct_model(pt_of(j % 4)) || err !== 1'b0)
                $display("FAIL rr_data job=%0d actual=%h/%b required=%h/0", j, ct, err, ct_model(pt_of(j % 4)));
            else n_pass++;
        end
        req_valid = '0;
    endtask

    task automatic test_rr_sparse();
        int gid, rid;
        logic [127:0] ct;
        logic err;
        bit ok;
        int exp_order [3] = '{3, 1, 3};
        req_valid = 4'b0010;
        serve(1, gid, rid, ct, err, ok);
        n_checks++;
        if (!ok || gid != 1) $display("FAIL rr_setup actual=%0d ok=%0d required=1", gid, ok); else n_pass++;
        req_valid = 4'b1010;
        for (int j = 0; j < 3; j++) begin
            serve(1, gid, rid, ct, err, ok);
            n_checks++;
            if (!ok || gid != exp_order[j] || ct !== ct_model(pt_of(exp_order[j])))
                $display("FAIL rr_sparse job=%0d actual=%0d ok=%0d required=%0d", j, gid, ok, exp_order[j]);
            else n_pass++;
        end
        req_valid = '0;
    endtask

    task automatic test_bad_keylen();
        int n, starts0;
        starts0 = start_count;
        req_key_len[2:0] = 3'b000;
        req_valid = 4'b0001;
        n = 0;
        while (req_ready == '0 && n < 20) begin tick(); n++; end
        n_checks++;
        if (req_ready !== 4'b0001 || resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_id !== 2'd0 || resp_ciphertext !== 128'd0)
            $display("FAIL badkl_resp actual=%b/%b/%b/%0d/%h required=0001/1/1/0/0", req_ready, resp_valid, resp_err, resp_id, resp_ciphertext);
        else n_pass++;
        req_valid = '0;
        req_key_len[2:0] = 3'b001;
        tick();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        tick();
        n_checks++;
        if (start_count != starts0 || resp_valid !== 1'b0 || resp_err !== 1'b0)
            $display("FAIL badkl_no_start actual=%0d/%b/%b required=%0d/0/0", start_count, resp_valid, resp_err, starts0);
        else n_pass++;
    endtask

    // Continues into a mid-job reset using the grant released by the stall.
    task automatic test_stall_and_reset();
        int n;
        bit stable;
        logic [127:0] exp_ct;
        exp_ct = ct_model(pt_of(1));
        req_valid = 4'b0010;
        n = 0;
        while (req_ready == '0 && n < 20) begin tick(); n++; end
        req_valid = 4'b0001;
        tick();
        core_ciphertext = ct_model(core_plaintext);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        core_ciphertext = '0;
        n_checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_ciphertext !== exp_ct)
            $display("FAIL stall_resp actual=%b/%0d/%h required=1/1/%h", resp_valid, resp_id, resp_ciphertext, exp_ct);
        else n_pass++;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_ciphertext !== exp_ct ||
                resp_err !== 1'b0 || req_ready !== 4'b0000 || core_start !== 1'b0)
                stable = 1'b0;
        end
        n_checks++;
        if (stable !== 1'b1) $display("FAIL stall_stable actual=%b required=1", stable); else n_pass++;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 4'b0000)
            $display("FAIL stall_release actual=%b/%b required=0/0000", resp_valid, req_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (req_ready !== 4'b0001) $display("FAIL stall_next_grant actual=%b required=0001", req_ready); else n_pass++;
        req_valid = '0;
        tick();
        n_checks++;
        if (core_start !== 1'b1 || core_plaintext !== pt_of(0))
            $display("FAIL midrst_start actual=%b/%h required=1/%h", core_start, core_plaintext, pt_of(0));
        else n_pass++;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (req_ready !== 4'b0000 || core_start !== 1'b0 || core_plaintext !== 128'd0 || core_key_len !== 3'd0 ||
            key_bank_sel !== 2'd0 || resp_valid !== 1'b0 || resp_id !== 2'd0 || resp_ciphertext !== 128'd0 || resp_err !== 1'b0)
            $display("FAIL midrst_values actual=%b/%b/%h/%b/%0d/%b/%0d/%h/%b required=all zero", req_ready, core_start,
                     core_plaintext, core_key_len, key_bank_sel, resp_valid, resp_id, resp_ciphertext, resp_err);
        else n_pass++;
        core_ciphertext = 128'hdead;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        core_ciphertext = '0;
        tick();
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 4'b0000)
            $display("FAIL midrst_stray_done actual=%b/%b required=0/0000", resp_valid, req_ready);
        else n_pass++;
    endtask

`ifdef AES_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        do_reset();
        req_valid = 4'b0100;
        n = 0;
        while (req_ready == '0 && n < 20) begin tick(); n++; end
        req_valid = '0;
        tick();
        n = 0;
        while (!resp_valid && n < 200) begin tick(); n++; end
        n_checks++;
        if (n != 64 || resp_err !== 1'b1 || resp_ciphertext !== 128'd0 || resp_id !== 2'd2)
            $display("FAIL timeout_resp actual=%0d/%b/%h/%0d required=64/1/0/2", n, resp_err, resp_ciphertext, resp_id);
        else n_pass++;
        core_ciphertext = CT_A;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        core_ciphertext = '0;
        n_checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_ciphertext !== 128'd0)
            $display("FAIL timeout_late_done actual=%b/%b/%h required=1/1/0", resp_valid, resp_err, resp_ciphertext);
        else n_pass++;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b1;
        set_default_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_rr_sparse();
        test_bad_keylen();
        test_stall_and_reset();
`ifdef AES_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=time limit reached required=bench completion");
        $fatal(1, "bench watchdog expired");
    end

endmodule
`default_nettype wire
